// File: rtl/controlador_carro.sv
// controlador_carro: game-side controller for one obstacle car. Spawns the car in a
// pseudo-random lane, steps it down one row per period, scores when it leaves the
// screen and parks it on collision. The step period shrinks as the level rises.
module controlador_carro #(
  parameter logic [19:0] PERIODO_INICIAL = 20'd833333,
  parameter logic [19:0] PERIODO_MIN     = 20'd2,
  parameter logic [19:0] PASO            = 20'd41666,
  parameter logic [7:0]  NIVEL_PUNTOS    = 8'd5,
  parameter logic [9:0]  CARRIL0         = 10'd160,
  parameter logic [9:0]  CARRIL1         = 10'd240,
  parameter logic [9:0]  CARRIL2         = 10'd320,
  parameter logic [9:0]  CARRIL3         = 10'd400,
  parameter logic [9:0]  PARQUEO_X       = 10'd639,
  parameter logic [8:0]  PARQUEO_Y       = 9'd0
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iChoque,
  input  logic       iEnableCuenta,
  input  logic       iEnableCero,
  output logic [9:0] oPosicionX,
  output logic [8:0] oPosicionY,
  output logic [9:0] oPosicionAuxX,
  output logic [8:0] oPosicionAuxY,
  output logic       oEnable,
  output logic       oSuma,
  output logic       oSalto,
  output logic [7:0] oPuntaje,
  output logic [3:0] oNivel,
  output logic       oJugando
);

  typedef enum logic [1:0] {IDLE, CARGA, MUEVE, FIN} estado_t;

  estado_t     estado_q, estado_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [19:0] contador_q, contador_d;
  logic [7:0]  puntaje_q, puntaje_d;
  logic [3:0]  nivel_q, nivel_d;
  logic [7:0]  pts_nivel_q, pts_nivel_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic        enable_q, enable_d;
  logic        suma_q, suma_d;
  logic        salto_q, salto_d;
  logic        jugando_q, jugando_d;

  logic [9:0]  carril;
  logic [23:0] reduccion;
  logic [19:0] periodo;

  // iEnableCero always arrives together with iEnableCuenta, so only the latter drives scoring
  logic unused_cero;
  assign unused_cero = iEnableCero;

  // Lane chosen by the two low LFSR bits
  always_comb begin
    carril = CARRIL0;
    case (lfsr_q[1:0])
      2'd0: carril = CARRIL0;
      2'd1: carril = CARRIL1;
      2'd2: carril = CARRIL2;
      default: carril = CARRIL3;
    endcase
  end

  // Step period for the current level, clamped to the floor before subtracting
  always_comb begin
    reduccion = 24'(nivel_q) * 24'(PASO);
    if ({4'd0, PERIODO_INICIAL} < reduccion + {4'd0, PERIODO_MIN}) begin
      periodo = PERIODO_MIN;
    end else begin
      periodo = PERIODO_INICIAL - reduccion[19:0];
    end
  end

  // Next-state logic: FSM, score/level bookkeeping and one-cycle pulses
  always_comb begin
    estado_d    = estado_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    contador_d  = contador_q;
    puntaje_d   = puntaje_q;
    nivel_d     = nivel_q;
    pts_nivel_d = pts_nivel_q;
    pos_x_d     = pos_x_q;
    enable_d    = 1'b0;
    suma_d      = 1'b0;
    salto_d     = 1'b0;
    case (estado_q)
      IDLE, FIN: begin
        if (iStart) begin
          estado_d    = CARGA;
          puntaje_d   = 8'd0;
          nivel_d     = 4'd0;
          pts_nivel_d = 8'd0;
        end
      end
      CARGA: begin
        enable_d   = 1'b1;
        pos_x_d    = carril;
        contador_d = 20'd0;
        estado_d   = MUEVE;
      end
      MUEVE: begin
        if (iChoque) begin
          salto_d  = 1'b1;
          estado_d = FIN;
        end else if (iEnableCuenta) begin
          estado_d = CARGA;
          if (puntaje_q != 8'd255) begin
            puntaje_d = puntaje_q + 8'd1;
            if (pts_nivel_q == NIVEL_PUNTOS - 8'd1) begin
              pts_nivel_d = 8'd0;
              if (nivel_q != 4'd15) begin
                nivel_d = nivel_q + 4'd1;
              end
            end else begin
              pts_nivel_d = pts_nivel_q + 8'd1;
            end
          end
        end else if (contador_q == periodo - 20'd1) begin
          suma_d     = 1'b1;
          contador_d = 20'd0;
        end else begin
          contador_d = contador_q + 20'd1;
        end
      end
      default: estado_d = IDLE;
    endcase
    jugando_d = (estado_d == CARGA) || (estado_d == MUEVE);
  end

  // State and registered outputs, synchronous reset overrides everything
  always_ff @(posedge iClk) begin
    if (iReset) begin
      estado_q    <= IDLE;
      lfsr_q      <= 8'hA5;
      contador_q  <= 20'd0;
      puntaje_q   <= 8'd0;
      nivel_q     <= 4'd0;
      pts_nivel_q <= 8'd0;
      pos_x_q     <= 10'd0;
      enable_q    <= 1'b0;
      suma_q      <= 1'b0;
      salto_q     <= 1'b0;
      jugando_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      lfsr_q      <= lfsr_d;
      contador_q  <= contador_d;
      puntaje_q   <= puntaje_d;
      nivel_q     <= nivel_d;
      pts_nivel_q <= pts_nivel_d;
      pos_x_q     <= pos_x_d;
      enable_q    <= enable_d;
      suma_q      <= suma_d;
      salto_q     <= salto_d;
      jugando_q   <= jugando_d;
    end
  end

  assign oPosicionX    = pos_x_q;
  assign oPosicionY    = 9'd0;
  assign oPosicionAuxX = PARQUEO_X;
  assign oPosicionAuxY = PARQUEO_Y;
  assign oEnable       = enable_q;
  assign oSuma         = suma_q;
  assign oSalto        = salto_q;
  assign oPuntaje      = puntaje_q;
  assign oNivel        = nivel_q;
  assign oJugando      = jugando_q;

endmodule

// File: tb/tb_controlador_carro.sv
// tb_controlador_carro: self-checking bench for controlador_carro with a short period
// (8 clocks, 2 per level, floor 2) and two points per level.
module tb_controlador_carro;

  localparam logic [19:0] P_INI  = 20'd8;
  localparam logic [19:0] P_MIN  = 20'd2;
  localparam logic [19:0] P_PASO = 20'd2;
  localparam logic [7:0]  P_NIV  = 8'd2;

  logic       iClk;
  logic       iReset;
  logic       iStart;
  logic       iChoque;
  logic       iEnableCuenta;
  logic       iEnableCero;
  logic [9:0] oPosicionX;
  logic [8:0] oPosicionY;
  logic [9:0] oPosicionAuxX;
  logic [8:0] oPosicionAuxY;
  logic       oEnable;
  logic       oSuma;
  logic       oSalto;
  logic [7:0] oPuntaje;
  logic [3:0] oNivel;
  logic       oJugando;

  controlador_carro #(
    .PERIODO_INICIAL(P_INI),
    .PERIODO_MIN(P_MIN),
    .PASO(P_PASO),
    .NIVEL_PUNTOS(P_NIV)
  ) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iStart(iStart),
    .iChoque(iChoque),
    .iEnableCuenta(iEnableCuenta),
    .iEnableCero(iEnableCero),
    .oPosicionX(oPosicionX),
    .oPosicionY(oPosicionY),
    .oPosicionAuxX(oPosicionAuxX),
    .oPosicionAuxY(oPosicionAuxY),
    .oEnable(oEnable),
    .oSuma(oSuma),
    .oSalto(oSalto),
    .oPuntaje(oPuntaje),
    .oNivel(oNivel),
    .oJugando(oJugando)
  );

  typedef struct {
    logic       start;
    logic       choque;
    logic       cuenta;
    logic       cero;
    logic       load;
    logic [7:0] puntaje;
    logic [3:0] nivel;
    logic       jugando;
  } vec_t;

  vec_t       tabla [12];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         exp_load_q [$];
  logic [7:0] lfsr_m;
  logic [7:0] lfsr_prev;
  logic [3:0] lanes_seen = 4'd0;

  // 100 MHz-style clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Cycle counter and reference LFSR, both advancing on every rising edge
  always @(posedge iClk) begin
    cyc       <= cyc + 1;
    lfsr_prev <= lfsr_m;
    if (iReset) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic check_output(input string nombre, input int actual, input int esperado);
    tests_run++;
    if (actual !== esperado) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nombre, actual, esperado, cyc);
    end
  endtask

  function automatic int lane_x(input logic [1:0] idx);
    case (idx)
      2'd0: return 160;
      2'd1: return 240;
      2'd2: return 320;
      default: return 400;
    endcase
  endfunction

  // Pulse exclusivity plus load scoreboard: every oEnable must match a pushed expectation
  always @(negedge iClk) begin
    if (oEnable || oSuma || oSalto) begin
      check_output("pulse_exclusive", int'(oEnable) + int'(oSuma) + int'(oSalto), 1);
    end
    if (oEnable) begin
      if (exp_load_q.size() == 0) begin
        check_output("unexpected_load", 1, 0);
      end else begin
        check_output("load_cycle", cyc, exp_load_q.pop_front());
      end
      check_output("spawn_x", int'(oPosicionX), lane_x(lfsr_prev[1:0]));
      check_output("spawn_y", int'(oPosicionY), 0);
      for (int k = 0; k < 4; k++) begin
        if (int'(oPosicionX) == lane_x(2'(k))) lanes_seen[k] = 1'b1;
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic apply_stimulus(input logic s, input logic ch, input logic cu, input logic ce,
                                input logic load);
    iStart        = s;
    iChoque       = ch;
    iEnableCuenta = cu;
    iEnableCero   = ce;
    if (load) exp_load_q.push_back(cyc + 2);
    tick();
    iStart        = 1'b0;
    iChoque       = 1'b0;
    iEnableCuenta = 1'b0;
    iEnableCero   = 1'b0;
  endtask

  task automatic score_point();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
  endtask

  task automatic wait_suma(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oSuma) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check_output("suma_timeout", 0, 1);
  endtask

  task automatic measure_spacing(input string nombre, input int esperado);
    int c1;
    int c2;
    wait_suma(c1);
    wait_suma(c2);
    check_output(nombre, c2 - c1, esperado);
  endtask

  initial begin
    int n;
    // start, choque, cuenta, cero, load, puntaje, nivel, jugando
    tabla[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0};
    tabla[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd0, 1'b0};
    tabla[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b1};
    tabla[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 4'd0, 1'b1};
    tabla[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 4'd1, 1'b1};
    tabla[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 1'b1};
    tabla[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 4'd1, 1'b1};
    tabla[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 4'd2, 1'b1};
    tabla[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 4'd2, 1'b1};
    tabla[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 4'd2, 1'b0};
    tabla[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 4'd2, 1'b0};
    tabla[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b1};

    iReset        = 1'b1;
    iStart        = 1'b0;
    iChoque       = 1'b0;
    iEnableCuenta = 1'b0;
    iEnableCero   = 1'b0;
    tick();
    tick();
    check_output("rst_enable", int'(oEnable), 0);
    check_output("rst_suma", int'(oSuma), 0);
    check_output("rst_salto", int'(oSalto), 0);
    check_output("rst_puntaje", int'(oPuntaje), 0);
    check_output("rst_nivel", int'(oNivel), 0);
    check_output("rst_jugando", int'(oJugando), 0);
    check_output("rst_pos_x", int'(oPosicionX), 0);
    check_output("rst_pos_y", int'(oPosicionY), 0);
    iReset = 1'b0;
    tick();

    // Table: events in IDLE, MUEVE and FIN with the score/level they must leave behind
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tabla[i].start, tabla[i].choque, tabla[i].cuenta, tabla[i].cero, tabla[i].load);
      check_output($sformatf("vec%0d_puntaje", i), int'(oPuntaje), int'(tabla[i].puntaje));
      check_output($sformatf("vec%0d_nivel", i), int'(oNivel), int'(tabla[i].nivel));
      check_output($sformatf("vec%0d_jugando", i), int'(oJugando), int'(tabla[i].jugando));
      tick();
      tick();
    end

    // Step spacing shrinks by 2 per level and floors at 2
    measure_spacing("spacing_lvl0", 8);
    score_point();
    check_output("b_puntaje1", int'(oPuntaje), 1);
    measure_spacing("spacing_lvl0b", 8);
    score_point();
    check_output("b_nivel1", int'(oNivel), 1);
    measure_spacing("spacing_lvl1", 6);
    score_point();
    score_point();
    check_output("b_nivel2", int'(oNivel), 2);
    measure_spacing("spacing_lvl2", 4);
    score_point();
    score_point();
    check_output("b_nivel3", int'(oNivel), 3);
    measure_spacing("spacing_lvl3", 2);
    score_point();
    score_point();
    check_output("b_nivel4", int'(oNivel), 4);
    check_output("b_puntaje8", int'(oPuntaje), 8);
    measure_spacing("spacing_lvl4", 2);

    // Collision parks the car and freezes the game
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("crash_salto", int'(oSalto), 1);
    check_output("crash_jugando", int'(oJugando), 0);
    check_output("crash_aux_x", int'(oPosicionAuxX), 639);
    check_output("crash_aux_y", int'(oPosicionAuxY), 0);
    check_output("crash_puntaje", int'(oPuntaje), 8);
    tick();
    check_output("crash_salto_off", int'(oSalto), 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (oSuma) n++;
    end
    check_output("fin_no_suma", n, 0);
    check_output("fin_jugando", int'(oJugando), 0);

    // Collision wins over a point arriving in the same cycle
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    score_point();
    check_output("c_puntaje1", int'(oPuntaje), 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_output("both_puntaje", int'(oPuntaje), 1);
    check_output("both_salto", int'(oSalto), 1);
    check_output("both_jugando", int'(oJugando), 0);
    tick();
    tick();

    // Restart from FIN clears score and level, then saturation
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("restart_puntaje", int'(oPuntaje), 0);
    check_output("restart_nivel", int'(oNivel), 0);
    check_output("restart_jugando", int'(oJugando), 1);
    tick();
    tick();
    for (int i = 0; i < 300; i++) begin
      score_point();
      if (i == 29) check_output("sat_nivel_at30", int'(oNivel), 15);
      if (i == 254) check_output("sat_puntaje_at255", int'(oPuntaje), 255);
    end
    check_output("sat_puntaje", int'(oPuntaje), 255);
    check_output("sat_nivel", int'(oNivel), 15);

    // Reset in the middle of MUEVE overrides simultaneous inputs
    tick();
    tick();
    tick();
    iReset        = 1'b1;
    iStart        = 1'b1;
    iEnableCuenta = 1'b1;
    tick();
    check_output("midrst_puntaje", int'(oPuntaje), 0);
    check_output("midrst_nivel", int'(oNivel), 0);
    check_output("midrst_jugando", int'(oJugando), 0);
    check_output("midrst_suma", int'(oSuma), 0);
    check_output("midrst_pos_x", int'(oPosicionX), 0);
    iReset        = 1'b0;
    iStart        = 1'b0;
    iEnableCuenta = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oSuma || oEnable || oJugando) n++;
    end
    check_output("idle_after_rst", n, 0);

    check_output("loads_pending", exp_load_q.size(), 0);
    check_output("lanes_varied", int'($countones(lanes_seen) > 1), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
